ring_counter_checker: RTL and testbench

Receiving-end companion to the ring counter. Samples an N-bit one-hot ring-counter output and decodes it to a binary index. Checks one-hot legality and correct rotation order, locks onto a healthy sequence and counts full rotations. Sits beside any ring_counter instance as an in-line monitor and decoder; it never drives the counter.

---
 rtl/ring_counter_checker_if.sv | 43 ++++
 rtl/ring_counter_checker.sv | 136 +++++++++++++
 tb/tb_ring_counter_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ring_counter_checker_if.sv
// ring_counter_checker_if
//   Bundles the sample/control inputs and the decoded status outputs of
//   ring_counter_checker. clk and reset stay plain ports on the module.
//   master : the driver side (supplies en, q_in, clr_err; observes status)
//   slave  : the checker itself
//   Signals:
//     en          sample qualifier
//     q_in[N]     monitored ring-counter state
//     clr_err     clear of sticky error flags
//     idx[IW]     index of the set bit of the last legal sample
//     valid       last sample was legal one-hot
//     locked      sequence tracking established
//     onehot_err  sticky illegal-sample flag
//     seq_err     sticky out-of-order flag
//     wrap        one-cycle rotation-complete pulse
//     wrap_count  completed rotations, modulo 2^WCW
interface ring_counter_checker_if #(
  parameter int N   = 8,
  parameter int WCW = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic           en;
  logic [N-1:0]   q_in;
  logic           clr_err;
  logic [IW-1:0]  idx;
  logic           valid;
  logic           locked;
  logic           onehot_err;
  logic           seq_err;
  logic           wrap;
  logic [WCW-1:0] wrap_count;

  modport master (
    output en, q_in, clr_err,
    input  idx, valid, locked, onehot_err, seq_err, wrap, wrap_count
  );

  modport slave (
    input  en, q_in, clr_err,
    output idx, valid, locked, onehot_err, seq_err, wrap, wrap_count
  );
endinterface

// File: rtl/ring_counter_checker.sv
// ring_counter_checker
//   In-line monitor/decoder for a one-hot ring counter. Each qualified sample
//   is checked for one-hot legality and for following the expected rotation
//   q <= {q[N-2:0], q[N-1]}. After RELOCK+1 consecutive in-order legal samples
//   the checker declares lock; while locked it counts completed rotations.
//   All outputs are registered, one clock after the sampled q_in.
//   Ports:
//     clk    rising-edge clock shared with the monitored counter
//     reset  asynchronous, active-low reset
//     bus    ring_counter_checker_if slave (en, q_in, clr_err in; idx, valid,
//            locked, onehot_err, seq_err, wrap, wrap_count out)
module ring_counter_checker #(
  parameter int N      = 8,
  parameter int RELOCK = 2,
  parameter int WCW    = 8
) (
  input  logic clk,
  input  logic reset,
  ring_counter_checker_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // run counts up to RELOCK+1, so it needs room for that value
  localparam int RW = $clog2(RELOCK + 2);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  function automatic logic is_onehot(input logic [N-1:0] s);
    // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    return (s != '0) && ((s & (s - N'(1))) == '0);
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] s);
    return {s[N-2:0], s[N-1]};
  endfunction

  function automatic logic [IW-1:0] encode(input logic [N-1:0] s);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) r = IW'(i);
    end
    return r;
  endfunction

  state_t         state;
  logic [RW-1:0]  run;
  logic [N-1:0]   exp_q;
  logic [IW-1:0]  idx_p1;
  logic           vld_p1;
  logic           locked_p1;
  logic           onehot_err_p1;
  logic           seq_err_p1;
  logic           wrap_p1;
  logic [WCW-1:0] wrap_count_p1;

  logic legal;
  logic match;

  assign legal = is_onehot(bus.q_in);
  assign match = (bus.q_in == exp_q);

  // sample stage -> registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ACQUIRE;
      run           <= '0;
      exp_q         <= '0;
      idx_p1        <= '0;
      vld_p1        <= 1'b0;
      locked_p1     <= 1'b0;
      onehot_err_p1 <= 1'b0;
      seq_err_p1    <= 1'b0;
      wrap_p1       <= 1'b0;
      wrap_count_p1 <= '0;
    end else begin
      wrap_p1 <= 1'b0;

      // clear first so that an error detected on the same edge overrides it
      if (bus.clr_err) begin
        onehot_err_p1 <= 1'b0;
        seq_err_p1    <= 1'b0;
      end

      if (!bus.en) begin
        vld_p1 <= 1'b0;
      end else if (!legal) begin
        vld_p1        <= 1'b0;
        onehot_err_p1 <= 1'b1;
        state         <= ACQUIRE;
        run           <= '0;
        locked_p1     <= 1'b0;
      end else begin
        vld_p1 <= 1'b1;
        idx_p1 <= encode(bus.q_in);
        exp_q  <= rotl(bus.q_in);
        case (state)
          ACQUIRE: begin
            // run==0 means no predecessor, so exp_q is not meaningful yet
            if ((run != '0) && match) begin
              run <= run + RW'(1);
              if (run == RW'(RELOCK)) begin
                state     <= LOCKED;
                locked_p1 <= 1'b1;
              end
            end else begin
              run <= RW'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              if (bus.q_in[0]) begin
                wrap_p1       <= 1'b1;
                wrap_count_p1 <= wrap_count_p1 + WCW'(1);
              end
            end else begin
              // this legal sample starts a fresh chain of length one
              seq_err_p1 <= 1'b1;
              locked_p1  <= 1'b0;
              state      <= ACQUIRE;
              run        <= RW'(1);
            end
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

  assign bus.idx        = idx_p1;
  assign bus.valid      = vld_p1;
  assign bus.locked     = locked_p1;
  assign bus.onehot_err = onehot_err_p1;
  assign bus.seq_err    = seq_err_p1;
  assign bus.wrap       = wrap_p1;
  assign bus.wrap_count = wrap_count_p1;
endmodule

// File: tb/tb_ring_counter_checker.sv
// tb_ring_counter_checker
//   Table-driven check of ring_counter_checker (N=8, RELOCK=2) plus
//   hand-written sequences for asynchronous reset, en stalls and the
//   rotation counter. A second instance with WCW=2 sees the same stimulus
//   and is used for the wrap-around of wrap_count.
module tb_ring_counter_checker;
  localparam int N      = 8;
  localparam int RELOCK = 2;
  localparam int WCW    = 8;

  typedef struct {
    logic       en;
    logic [7:0] q;
    logic       clr;
    logic [2:0] idx;
    logic       v;
    logic       l;
    logic       oh;
    logic       sq;
    logic       w;
    logic [7:0] wc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ring_counter_checker_if #(.N(N), .WCW(WCW)) bus  ();
  ring_counter_checker_if #(.N(N), .WCW(2))   bus2 ();

  assign bus2.en      = bus.en;
  assign bus2.q_in    = bus.q_in;
  assign bus2.clr_err = bus.clr_err;

  ring_counter_checker #(.N(N), .RELOCK(RELOCK), .WCW(WCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ring_counter_checker #(.N(N), .RELOCK(RELOCK), .WCW(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  int   wraps;

  task automatic add(input logic en, input logic [7:0] q, input logic clr,
                     input logic [2:0] idx, input logic v, input logic l,
                     input logic oh, input logic sq, input logic w,
                     input logic [7:0] wc);
    vec_t t;
    t.en = en; t.q = q; t.clr = clr; t.idx = idx; t.v = v; t.l = l;
    t.oh = oh; t.sq = sq; t.w = w; t.wc = wc;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [15:0] obs();
    return {bus.idx, bus.valid, bus.locked, bus.onehot_err, bus.seq_err,
            bus.wrap, bus.wrap_count};
  endfunction

  function automatic logic [15:0] pack(input logic [2:0] idx, input logic v,
                                       input logic l, input logic oh,
                                       input logic sq, input logic w,
                                       input logic [7:0] wc);
    return {idx, v, l, oh, sq, w, wc};
  endfunction

  // drive at the falling edge, sample 1 ns after the next rising edge
  task automatic step(input logic en, input logic [7:0] q, input logic clr);
    @(negedge clk);
    bus.en      = en;
    bus.q_in    = q;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // clean lock, rotation, wrap
    add(1, 8'h01, 0, 0, 1, 0, 0, 0, 0, 8'd0);
    add(1, 8'h02, 0, 1, 1, 0, 0, 0, 0, 8'd0);
    add(1, 8'h04, 0, 2, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h08, 0, 3, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h10, 0, 4, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h20, 0, 5, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h40, 0, 6, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h80, 0, 7, 1, 1, 0, 0, 0, 8'd0);
    add(1, 8'h01, 0, 0, 1, 1, 0, 0, 1, 8'd1);
    add(1, 8'h02, 0, 1, 1, 1, 0, 0, 0, 8'd1);
    add(1, 8'h04, 0, 2, 1, 1, 0, 0, 0, 8'd1);
    // illegal sample while locked, then re-acquire
    add(1, 8'h03, 0, 2, 0, 0, 1, 0, 0, 8'd1);
    add(1, 8'h08, 0, 3, 1, 0, 1, 0, 0, 8'd1);
    add(1, 8'h10, 0, 4, 1, 0, 1, 0, 0, 8'd1);
    add(1, 8'h20, 0, 5, 1, 1, 1, 0, 0, 8'd1);
    add(1, 8'h40, 0, 6, 1, 1, 1, 0, 0, 8'd1);
    add(1, 8'h80, 0, 7, 1, 1, 1, 0, 0, 8'd1);
    add(1, 8'h01, 0, 0, 1, 1, 1, 0, 1, 8'd2);
    add(1, 8'h02, 0, 1, 1, 1, 1, 0, 0, 8'd2);
    add(1, 8'h04, 0, 2, 1, 1, 1, 0, 0, 8'd2);
    // skip 08 -> sequence error, re-acquire
    add(1, 8'h10, 0, 4, 1, 0, 1, 1, 0, 8'd2);
    add(1, 8'h20, 0, 5, 1, 0, 1, 1, 0, 8'd2);
    add(1, 8'h40, 0, 6, 1, 1, 1, 1, 0, 8'd2);
    // clear flags, lock kept
    add(0, 8'h80, 1, 6, 0, 1, 0, 0, 0, 8'd2);
    add(1, 8'h80, 0, 7, 1, 1, 0, 0, 0, 8'd2);
    // error set wins over clear; zero and all-ones are illegal
    add(1, 8'h00, 1, 7, 0, 0, 1, 0, 0, 8'd2);
    add(1, 8'hFF, 1, 7, 0, 0, 1, 0, 0, 8'd2);
    add(0, 8'h00, 1, 7, 0, 0, 0, 0, 0, 8'd2);

    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.q_in    = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {16'h0, obs()}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].q, tbl[i].clr);
      check($sformatf("vec%0d", i), {16'h0, obs()},
            {16'h0, pack(tbl[i].idx, tbl[i].v, tbl[i].l, tbl[i].oh,
                         tbl[i].sq, tbl[i].w, tbl[i].wc)});
    end

    // asynchronous reset in the middle of a locked run
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h04, 0);
    check("pre_reset_locked", {16'h0, obs()}, {16'h0, pack(2, 1, 1, 0, 0, 0, 8'd2)});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {16'h0, obs()}, 32'h0);
    check("async_reset_wc2", {30'h0, bus2.wrap_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 8'h01, 0);
    check("relock_01", {16'h0, obs()}, {16'h0, pack(0, 1, 0, 0, 0, 0, 8'd0)});
    step(1, 8'h02, 0);
    check("relock_02", {16'h0, obs()}, {16'h0, pack(1, 1, 0, 0, 0, 0, 8'd0)});
    step(1, 8'h04, 0);
    check("relock_04", {16'h0, obs()}, {16'h0, pack(2, 1, 1, 0, 0, 0, 8'd0)});

    // en stall while locked; q_in is garbage during the stall
    step(1, 8'h08, 0);
    check("stall_pre", {16'h0, obs()}, {16'h0, pack(3, 1, 1, 0, 0, 0, 8'd0)});
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 0);
      check($sformatf("stall%0d", i), {16'h0, obs()},
            {16'h0, pack(3, 0, 1, 0, 0, 0, 8'd0)});
    end
    step(1, 8'h10, 0);
    check("stall_post", {16'h0, obs()}, {16'h0, pack(4, 1, 1, 0, 0, 0, 8'd0)});
    // a held value is an out-of-order sample
    step(1, 8'h10, 0);
    check("repeat_seq_err", {16'h0, obs()}, {16'h0, pack(4, 1, 0, 0, 1, 0, 8'd0)});

    // four clean rotations on the WCW=2 instance
    @(negedge clk);
    reset = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wraps = 0;
    for (int i = 0; i < 33; i++) begin
      logic [7:0] q;
      logic       want_w;
      q = 8'h01 << (i % 8);
      want_w = (i > 0) && ((i % 8) == 0);
      step(1, q, 0);
      check($sformatf("rot_wrap%0d", i), {31'h0, bus2.wrap}, {31'h0, want_w});
      if (bus2.wrap) wraps++;
      if (want_w)
        check($sformatf("rot_wc%0d", i), {30'h0, bus2.wrap_count},
              32'((i / 8) % 4));
    end
    check("rot_pulses", 32'(wraps), 32'd4);
    check("rot_wc2_final", {30'h0, bus2.wrap_count}, 32'd0);
    check("rot_wc8_final", {24'h0, bus.wrap_count}, 32'd4);
    check("rot_flags", {28'h0, bus2.locked, bus2.onehot_err, bus2.seq_err, bus2.valid},
          32'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
